// File: rtl/pong_pkg.sv
// Shared constants and types for the pong framebuffer path.
// Addresses are linear pixel indices: y*SCREEN_W + x.
package pong_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned ADDR_W   = 19;
    localparam int unsigned MAX_ADDR = SCREEN_W * SCREEN_H - 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OWN_PAD  = 2'd1,
        ST_OWN_BALL = 2'd2
    } arb_state_t;

    typedef enum logic {
        RR_PAD  = 1'b0,
        RR_BALL = 1'b1
    } rr_sel_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Per-writer wait counter with a sticky starvation flag.
// The counter saturates at MAX_WAIT; the flag is set on the edge the counter reaches it.
module arb_wait_counter #(
    parameter int unsigned MAX_WAIT = 1023
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    input  logic i_gnt,
    input  logic i_clr,
    output logic o_starve
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

    logic [CW-1:0] r_cnt;
    logic          r_starve;
    logic          w_waiting;
    logic          w_set;

    assign w_waiting = i_req & ~i_gnt;
    assign w_set     = w_waiting & (r_cnt >= LIMIT - 1'b1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!w_waiting) begin
            r_cnt <= '0;
        end else if (r_cnt != LIMIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A set in the same cycle as a clear wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_starve <= 1'b0;
        end else if (w_set) begin
            r_starve <= 1'b1;
        end else if (i_clr) begin
            r_starve <= 1'b0;
        end
    end

    assign o_starve = r_starve;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads first, then paddle/ball writers
// round-robin, with optional lock for atomic multi-write bursts.
module fb_arbiter
    import pong_pkg::*;
#(
    parameter int unsigned ADDR_W   = pong_pkg::ADDR_W,
    parameter int unsigned MAX_WAIT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_re,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_rdata,
    output logic              scan_rvalid,
    input  logic              pad_req,
    input  logic              pad_lock,
    input  logic [ADDR_W-1:0] pad_addr,
    input  logic              pad_wdata,
    output logic              pad_gnt,
    input  logic              ball_req,
    input  logic              ball_lock,
    input  logic [ADDR_W-1:0] ball_addr,
    input  logic              ball_wdata,
    output logic              ball_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wdata,
    input  logic              mem_rdata,
    output logic [1:0]        starve,
    input  logic              starve_clr
);

    arb_state_t r_state, w_state_nxt;
    rr_sel_t    r_rr, w_rr_nxt;
    logic       r_rvalid;
    logic       r_rdata;
    logic       w_pad_gnt;
    logic       w_ball_gnt;
    logic       w_pad_starve;
    logic       w_ball_starve;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rr     <= RR_PAD;
            r_rvalid <= 1'b0;
            r_rdata  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr     <= w_rr_nxt;
            r_rvalid <= scan_re;
            if (scan_re) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    // Grant decode is gated by reset so nothing reaches the RAM while reset is high.
    always_comb begin
        w_pad_gnt  = 1'b0;
        w_ball_gnt = 1'b0;
        if (!reset && !scan_re) begin
            case (r_state)
                ST_IDLE: begin
                    if (pad_req && ball_req) begin
                        if (r_rr == RR_PAD) begin
                            w_pad_gnt = 1'b1;
                        end else begin
                            w_ball_gnt = 1'b1;
                        end
                    end else if (pad_req) begin
                        w_pad_gnt = 1'b1;
                    end else if (ball_req) begin
                        w_ball_gnt = 1'b1;
                    end
                end
                ST_OWN_PAD:  w_pad_gnt  = pad_req;
                ST_OWN_BALL: w_ball_gnt = ball_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        if (!scan_re) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pad_gnt && pad_lock) begin
                        w_state_nxt = ST_OWN_PAD;
                    end else if (w_ball_gnt && ball_lock) begin
                        w_state_nxt = ST_OWN_BALL;
                    end
                end
                ST_OWN_PAD: begin
                    if (!pad_lock) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_OWN_BALL: begin
                    if (!ball_lock) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
        if (w_pad_gnt) begin
            w_rr_nxt = RR_BALL;
        end else if (w_ball_gnt) begin
            w_rr_nxt = RR_PAD;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 1'b0;
        if (!reset) begin
            if (scan_re) begin
                mem_en   = 1'b1;
                mem_addr = scan_addr;
            end else if (w_pad_gnt) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = pad_addr;
                mem_wdata = pad_wdata;
            end else if (w_ball_gnt) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ball_addr;
                mem_wdata = ball_wdata;
            end
        end
    end

    arb_wait_counter #(
        .MAX_WAIT(MAX_WAIT)
    ) u_pad_wait (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_req   (pad_req),
        .i_gnt   (w_pad_gnt),
        .i_clr   (starve_clr),
        .o_starve(w_pad_starve)
    );

    arb_wait_counter #(
        .MAX_WAIT(MAX_WAIT)
    ) u_ball_wait (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_req   (ball_req),
        .i_gnt   (w_ball_gnt),
        .i_clr   (starve_clr),
        .o_starve(w_ball_starve)
    );

    assign pad_gnt     = w_pad_gnt;
    assign ball_gnt    = w_ball_gnt;
    assign scan_rvalid = r_rvalid;
    assign scan_rdata  = r_rdata;
    assign starve      = {w_ball_starve, w_pad_starve};

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: inputs change 1ns after posedge, outputs checked mid-cycle.
module tb_fb_arbiter;

    localparam int unsigned AW = 19;

    logic          clk = 1'b0;
    logic          reset;
    logic          scan_re;
    logic [AW-1:0] scan_addr;
    logic          scan_rdata;
    logic          scan_rvalid;
    logic          pad_req, pad_lock, pad_wdata, pad_gnt;
    logic [AW-1:0] pad_addr;
    logic          ball_req, ball_lock, ball_wdata, ball_gnt;
    logic [AW-1:0] ball_addr;
    logic          mem_en, mem_we, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    starve;
    logic          starve_clr;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned writes = 0;

    fb_arbiter #(
        .ADDR_W  (AW),
        .MAX_WAIT(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_re    (scan_re),
        .scan_addr  (scan_addr),
        .scan_rdata (scan_rdata),
        .scan_rvalid(scan_rvalid),
        .pad_req    (pad_req),
        .pad_lock   (pad_lock),
        .pad_addr   (pad_addr),
        .pad_wdata  (pad_wdata),
        .pad_gnt    (pad_gnt),
        .ball_req   (ball_req),
        .ball_lock  (ball_lock),
        .ball_addr  (ball_addr),
        .ball_wdata (ball_wdata),
        .ball_gnt   (ball_gnt),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .starve     (starve),
        .starve_clr (starve_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        reset = 1'b1; scan_re = 1'b0; scan_addr = '0; mem_rdata = 1'b0; starve_clr = 1'b0;
        pad_req = 1'b0; pad_lock = 1'b0; pad_addr = '0; pad_wdata = 1'b0;
        ball_req = 1'b0; ball_lock = 1'b0; ball_addr = '0; ball_wdata = 1'b0;

        // Reset state
        #2;
        chk("rst_pad_gnt", {31'd0, pad_gnt}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_rvalid", {31'd0, scan_rvalid}, 32'd0);
        chk("rst_rdata", {31'd0, scan_rdata}, 32'd0);
        chk("rst_starve", {30'd0, starve}, 32'd0);
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Single paddle write, zero-cycle grant
        next_cycle();
        pad_req = 1'b1; pad_addr = 19'd1000; pad_wdata = 1'b1;
        settle();
        chk("t1_pad_gnt", {31'd0, pad_gnt}, 32'd1);
        chk("t1_ball_gnt", {31'd0, ball_gnt}, 32'd0);
        chk("t1_mem_en", {31'd0, mem_en}, 32'd1);
        chk("t1_mem_we", {31'd0, mem_we}, 32'd1);
        chk("t1_mem_addr", {13'd0, mem_addr}, 32'd1000);
        chk("t1_mem_wdata", {31'd0, mem_wdata}, 32'd1);

        // Ball locks for 5 writes; pad waits and starves after 4 cycles
        next_cycle();
        pad_addr = 19'd2000; pad_wdata = 1'b0;
        ball_req = 1'b1; ball_lock = 1'b1; ball_wdata = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            ball_addr = 19'(3000 + i);
            settle();
            chk("t3_ball_gnt", {31'd0, ball_gnt}, 32'd1);
            chk("t3_pad_gnt", {31'd0, pad_gnt}, 32'd0);
            chk("t3_mem_addr", {13'd0, mem_addr}, 32'(3000 + i));
            if (i == 3) chk("t3_starve_before", {30'd0, starve}, 32'd0);
            if (i == 4) chk("t3_starve_set", {30'd0, starve}, 32'd1);
        end
        next_cycle();
        ball_req = 1'b0; ball_lock = 1'b0;
        settle();
        chk("t3_unlock_pad_gnt", {31'd0, pad_gnt}, 32'd0);
        chk("t3_unlock_mem_en", {31'd0, mem_en}, 32'd0);
        next_cycle();
        settle();
        chk("t3_after_pad_gnt", {31'd0, pad_gnt}, 32'd1);
        chk("t3_after_addr", {13'd0, mem_addr}, 32'd2000);
        chk("t3_after_wdata", {31'd0, mem_wdata}, 32'd0);
        next_cycle();
        pad_req = 1'b0; starve_clr = 1'b1;
        settle();
        chk("t3_sticky", {30'd0, starve}, 32'd1);
        next_cycle();
        starve_clr = 1'b0;
        settle();
        chk("t3_cleared", {30'd0, starve}, 32'd0);

        // Fresh reset, then alternating grants starting with pad
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        next_cycle();
        pad_req = 1'b1; ball_req = 1'b1; pad_addr = 19'd10; ball_addr = 19'd20;
        writes = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next_cycle();
            settle();
            chk("t2_pad_gnt", {31'd0, pad_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_ball_gnt", {31'd0, ball_gnt}, (i % 2 == 0) ? 32'd0 : 32'd1);
            if (mem_en && mem_we) writes++;
        end
        chk("t2_write_count", writes, 32'd8);
        chk("t2_no_starve", {30'd0, starve}, 32'd0);

        // Scan read of last pixel blocks the paddle writer
        next_cycle();
        ball_req = 1'b0;
        pad_addr = 19'd5; pad_wdata = 1'b1;
        scan_re = 1'b1; scan_addr = 19'd307199; mem_rdata = 1'b1;
        settle();
        chk("t4_pad_gnt", {31'd0, pad_gnt}, 32'd0);
        chk("t4_mem_we", {31'd0, mem_we}, 32'd0);
        chk("t4_mem_en", {31'd0, mem_en}, 32'd1);
        chk("t4_mem_addr", {13'd0, mem_addr}, 32'd307199);
        next_cycle();
        scan_re = 1'b0;
        settle();
        chk("t4_rvalid", {31'd0, scan_rvalid}, 32'd1);
        chk("t4_rdata1", {31'd0, scan_rdata}, 32'd1);
        chk("t4_pad_gnt_after", {31'd0, pad_gnt}, 32'd1);
        next_cycle();
        pad_req = 1'b0;
        scan_re = 1'b1; scan_addr = 19'd12; mem_rdata = 1'b0;
        next_cycle();
        scan_re = 1'b0;
        settle();
        chk("t4_rvalid2", {31'd0, scan_rvalid}, 32'd1);
        chk("t4_rdata0", {31'd0, scan_rdata}, 32'd0);
        next_cycle();
        settle();
        chk("t4_rvalid_drop", {31'd0, scan_rvalid}, 32'd0);

        // Ball starves under continuous scan; set beats a simultaneous clear
        next_cycle();
        scan_re = 1'b1; ball_req = 1'b1; ball_addr = 19'd40;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            starve_clr = (i == 3);
            settle();
            chk("t5_ball_gnt", {31'd0, ball_gnt}, 32'd0);
            chk("t5_starve", {30'd0, starve}, (i == 4) ? 32'd2 : 32'd0);
        end
        next_cycle();
        starve_clr = 1'b0; scan_re = 1'b0;
        settle();
        chk("t5_ball_gnt_after", {31'd0, ball_gnt}, 32'd1);
        next_cycle();
        ball_req = 1'b0; starve_clr = 1'b1;
        next_cycle();
        starve_clr = 1'b0;
        settle();
        chk("t5_cleared", {30'd0, starve}, 32'd0);

        // Reset during a paddle lock
        next_cycle();
        pad_req = 1'b1; pad_lock = 1'b1; pad_addr = 19'd77;
        settle();
        chk("t6_pad_gnt", {31'd0, pad_gnt}, 32'd1);
        next_cycle();
        pad_req = 1'b0; ball_req = 1'b1; ball_addr = 19'd88;
        settle();
        chk("t6_owned_ball_gnt", {31'd0, ball_gnt}, 32'd0);
        chk("t6_owned_mem_en", {31'd0, mem_en}, 32'd0);
        next_cycle();
        pad_req = 1'b1; reset = 1'b1;
        settle();
        chk("t6_rst_pad_gnt", {31'd0, pad_gnt}, 32'd0);
        chk("t6_rst_ball_gnt", {31'd0, ball_gnt}, 32'd0);
        chk("t6_rst_mem_en", {31'd0, mem_en}, 32'd0);
        next_cycle();
        settle();
        chk("t6_rst_mem_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        reset = 1'b0; pad_req = 1'b0;
        settle();
        chk("t6_post_ball_gnt", {31'd0, ball_gnt}, 32'd1);
        chk("t6_post_addr", {13'd0, mem_addr}, 32'd88);
        chk("t6_post_pad_gnt", {31'd0, pad_gnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
